// File: rtl/reaction_timer_core.sv
// Reaction-time measurement FSM: random pre-stimulus delay, millisecond count to the react press,
// false-start detection. Feeds the 4-digit display driver (value, show_error).
module reaction_timer_core #(
  parameter int unsigned CLKS_PER_MS = 10000,
  parameter int unsigned MIN_WAIT_MS = 1000,
  parameter logic [15:0] RAND_MASK   = 16'h07FF,
  parameter int unsigned MAX_MS      = 9999,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        react_btn,
  output logic        led,
  output logic [13:0] value,
  output logic        show_error,
  output logic        busy
);

  localparam int unsigned PreW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(CLKS_PER_MS - 1);
  localparam logic [16:0] MaxLast = 17'(MAX_MS - 1);
  localparam logic [13:0] MaxVal  = 14'(MAX_MS);
  localparam logic [16:0] MinWait = 17'(MIN_WAIT_MS);

  typedef enum logic [2:0] {StIdle, StWait, StGo, StDone, StError} state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [16:0]     ms_q, ms_d;
  logic [16:0]     delay_q, delay_d;
  logic [13:0]     value_q, value_d;
  logic            start_prev_q, react_prev_q;
  logic            led_q, busy_q, err_q;
  logic            start_ev, react_ev, tick, transition, counting;

  assign start_ev = start_btn & ~start_prev_q;
  assign react_ev = react_btn & ~react_prev_q;
  assign tick     = (pre_q == PreLast);
  assign counting = (state_q == StWait) || (state_q == StGo);

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    delay_d = delay_q;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    unique case (state_q)
      StIdle, StDone, StError: begin
        // react is ignored here, so a simultaneous start still arms the test
        if (start_ev) begin
          state_d = StWait;
          value_d = '0;
          delay_d = MinWait + 17'(lfsr_q & RAND_MASK);
        end
      end
      StWait: begin
        if (react_ev) begin
          state_d = StError;
        end else if (tick && (ms_q == delay_q - 17'd1)) begin
          state_d = StGo;
        end
      end
      StGo: begin
        // react beats a coincident tick: only completed milliseconds are reported
        if (react_ev) begin
          state_d = StDone;
          value_d = ms_q[13:0];
        end else if (tick && (ms_q == MaxLast)) begin
          state_d = StDone;
          value_d = MaxVal;
        end
      end
      default: state_d = StIdle;
    endcase

    transition = (state_d != state_q);
    if (transition || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PreW'(1);
    end
    if (transition) begin
      ms_d = '0;
    end else if (tick && counting) begin
      ms_d = ms_q + 17'd1;
    end else begin
      ms_d = ms_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      lfsr_q       <= LFSR_SEED;
      pre_q        <= '0;
      ms_q         <= '0;
      delay_q      <= '0;
      value_q      <= '0;
      // held buttons must not look like fresh presses after reset
      start_prev_q <= 1'b1;
      react_prev_q <= 1'b1;
      led_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      pre_q        <= pre_d;
      ms_q         <= ms_d;
      delay_q      <= delay_d;
      value_q      <= value_d;
      start_prev_q <= start_btn;
      react_prev_q <= react_btn;
      led_q        <= (state_d == StGo);
      busy_q       <= (state_d == StWait) || (state_d == StGo);
      err_q        <= (state_d == StError);
    end
  end

  assign led        = led_q;
  assign busy       = busy_q;
  assign show_error = err_q;
  assign value      = value_q;

endmodule
